// File: rtl/liteic_pkg.sv
// Shared constants and types for the liteic crossbar nodes.
package liteic_pkg;

  localparam int IC_NUM_MASTER_SLOTS = 4;
  localparam int IC_ARADDR_WIDTH     = 32;
  localparam int IC_DATA_WIDTH       = 32;
  // Response word carries {r_data, r_resp}.
  localparam int IC_RDATA_WIDTH      = IC_DATA_WIDTH + 2;
  localparam int IC_QOS_WIDTH        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } liteic_slv_rd_state_t;

  // Width of an index into n slots; never zero so single-slot builds stay legal.
  function automatic int ic_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle between a crossbar node and a slave.
interface axi_lite_if
  import liteic_pkg::*;
#(
  parameter int ADDR_W = IC_ARADDR_WIDTH,
  parameter int DATA_W = IC_DATA_WIDTH
);
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_W-1:0]       ar_addr;
  logic [IC_QOS_WIDTH-1:0] ar_qos;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_W-1:0]       r_data;
  logic [1:0]              r_resp;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_W-1:0]       aw_addr;
  logic [IC_QOS_WIDTH-1:0] aw_qos;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_W-1:0]       w_data;
  logic [DATA_W/8-1:0]     w_strb;
  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;

  modport master (
    output ar_valid, ar_addr, ar_qos, r_ready,
    output aw_valid, aw_addr, aw_qos, w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp,
    input  aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_addr, ar_qos, r_ready,
    input  aw_valid, aw_addr, aw_qos, w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp,
    output aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/liteic_qos_rr_arbiter.sv
// Combinational arbiter: highest QoS wins, round-robin among equal QoS.
module liteic_qos_rr_arbiter
  import liteic_pkg::*;
#(
  parameter int N     = IC_NUM_MASTER_SLOTS,
  parameter int IDX_W = ic_idx_w(N)
) (
  input  logic [N-1:0]            req_i,
  input  logic [IC_QOS_WIDTH-1:0] qos_i [N],
  input  logic [IDX_W-1:0]        rr_last_i,
  output logic [N-1:0]            grant_o
);

  logic [IC_QOS_WIDTH-1:0] max_qos;
  logic [N-1:0]            top_mask;
  logic                    found;

  // Highest QoS among the active requesters.
  always_comb begin
    max_qos = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && (qos_i[i] > max_qos)) begin
        max_qos = qos_i[i];
      end
    end
  end

  // Keep only requesters that reached that QoS level.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign top_mask[gi] = req_i[gi] && (qos_i[gi] == max_qos);
    end
  endgenerate

  // Walk upward from the slot after rr_last, wrapping; first masked requester wins.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int off = 1; off <= N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && top_mask[i] && (i == ((int'(rr_last_i) + off) % N))) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/liteic_slave_node_read.sv
// Slave-side read node: arbitrates master AR requests and routes R back to the winner.
module liteic_slave_node_read
  import liteic_pkg::*;
#(
  parameter int                 NUM_MST  = IC_NUM_MASTER_SLOTS,
  parameter logic [NUM_MST-1:0] MST_MASK = '1,
  parameter int                 ADDR_W   = IC_ARADDR_WIDTH,
  parameter int                 RDATA_W  = IC_RDATA_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [NUM_MST-1:0]      cbar_reqst_val_i,
  input  logic [ADDR_W-1:0]       cbar_reqst_data_i [NUM_MST],
  input  logic [IC_QOS_WIDTH-1:0] cbar_reqst_arqos_i [NUM_MST],
  output logic [NUM_MST-1:0]      cbar_reqst_rdy_o,
  output logic [RDATA_W-1:0]      cbar_resp_data_o,
  output logic [NUM_MST-1:0]      cbar_resp_val_o,
  input  logic [NUM_MST-1:0]      cbar_resp_rdy_i,
  axi_lite_if.master              slv_axil
);

  localparam int IDX_W = ic_idx_w(NUM_MST);

  liteic_slv_rd_state_t    state_q, state_d;
  logic [NUM_MST-1:0]      grant_q, grant_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [IC_QOS_WIDTH-1:0] qos_q, qos_d;
  logic [IDX_W-1:0]        rr_last_q, rr_last_d;

  logic [NUM_MST-1:0]      req;
  logic [NUM_MST-1:0]      arb_grant;
  logic [ADDR_W-1:0]       win_addr;
  logic [IC_QOS_WIDTH-1:0] win_qos;
  logic [IDX_W-1:0]        grant_idx;
  logic                    ar_valid;
  logic                    r_ready;

  // Masters outside the connectivity mask are invisible to arbitration.
  assign req = cbar_reqst_val_i & MST_MASK;

  liteic_qos_rr_arbiter #(
    .N     (NUM_MST),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i     (req),
    .qos_i     (cbar_reqst_arqos_i),
    .rr_last_i (rr_last_q),
    .grant_o   (arb_grant)
  );

  // Select the winning master's address and QoS (grant is one-hot).
  always_comb begin
    win_addr = '0;
    win_qos  = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (arb_grant[i]) begin
        win_addr = cbar_reqst_data_i[i];
        win_qos  = cbar_reqst_arqos_i[i];
      end
    end
  end

  // Index of the registered grant, remembered as the round-robin pointer on completion.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (grant_q[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  // Next-state and output decode; every output idles low outside its own state.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    addr_d           = addr_q;
    qos_d            = qos_q;
    rr_last_d        = rr_last_q;
    ar_valid         = 1'b0;
    r_ready          = 1'b0;
    cbar_reqst_rdy_o = '0;
    cbar_resp_val_o  = '0;
    cbar_resp_data_o = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = arb_grant;
          addr_d  = win_addr;
          qos_d   = win_qos;
          state_d = AR;
        end
      end
      AR: begin
        ar_valid         = 1'b1;
        // Ack the master in the very cycle the slave accepts the address.
        cbar_reqst_rdy_o = grant_q & {NUM_MST{slv_axil.ar_ready}};
        if (slv_axil.ar_ready) begin
          state_d = R;
        end
      end
      R: begin
        cbar_resp_val_o  = grant_q & {NUM_MST{slv_axil.r_valid}};
        cbar_resp_data_o = {slv_axil.r_data, slv_axil.r_resp};
        r_ready          = |(cbar_resp_rdy_i & grant_q);
        if (slv_axil.r_valid && r_ready) begin
          rr_last_d = grant_idx;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset parks the pointer so master 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      addr_q    <= '0;
      qos_q     <= '0;
      rr_last_q <= IDX_W'(NUM_MST - 1);
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      qos_q     <= qos_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign slv_axil.ar_valid = ar_valid;
  assign slv_axil.ar_addr  = addr_q;
  assign slv_axil.ar_qos   = qos_q;
  assign slv_axil.r_ready  = r_ready;

  // This node only reads; the write channels stay quiet.
  assign slv_axil.aw_valid = 1'b0;
  assign slv_axil.aw_addr  = '0;
  assign slv_axil.aw_qos   = '0;
  assign slv_axil.w_valid  = 1'b0;
  assign slv_axil.w_data   = '0;
  assign slv_axil.w_strb   = '0;
  assign slv_axil.b_ready  = 1'b0;

endmodule

// File: tb/tb_liteic_slave_node_read.sv
// Scoreboard bench for liteic_slave_node_read with a behavioural slave and masters.
module tb_liteic_slave_node_read;

  localparam int NM = 4;

  typedef struct {
    int          mst;
    logic [31:0] addr;
    logic [3:0]  qos;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        rstn_m;
  logic [3:0]  req_val;
  logic [31:0] req_addr [NM];
  logic [3:0]  req_qos  [NM];
  logic [3:0]  reqst_rdy, reqst_rdy_m;
  logic [3:0]  resp_val, resp_val_m;
  logic [3:0]  resp_rdy;
  logic [33:0] resp_data, resp_data_m;

  axi_lite_if axs ();
  axi_lite_if axm ();

  liteic_slave_node_read dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .cbar_reqst_val_i   (req_val),
    .cbar_reqst_data_i  (req_addr),
    .cbar_reqst_arqos_i (req_qos),
    .cbar_reqst_rdy_o   (reqst_rdy),
    .cbar_resp_data_o   (resp_data),
    .cbar_resp_val_o    (resp_val),
    .cbar_resp_rdy_i    (resp_rdy),
    .slv_axil           (axs)
  );

  liteic_slave_node_read #(.MST_MASK(4'b1101)) dut_m (
    .clk_i              (clk),
    .rstn_i             (rstn_m),
    .cbar_reqst_val_i   (req_val),
    .cbar_reqst_data_i  (req_addr),
    .cbar_reqst_arqos_i (req_qos),
    .cbar_reqst_rdy_o   (reqst_rdy_m),
    .cbar_resp_data_o   (resp_data_m),
    .cbar_resp_val_o    (resp_val_m),
    .cbar_resp_rdy_i    (resp_rdy),
    .slv_axil           (axm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb [$];
  exp_t cur;
  bit   in_flight = 1'b0;
  bit   mask_phase = 1'b0;
  int   hs_cyc [$];
  int   arv_run = 0, last_arv = 0, rv_run = 0, last_rv = 0;

  // Pending requests per master and knobs (-1 means random 0..3 wait cycles).
  logic [31:0] m_addr [NM][32];
  logic [3:0]  m_qos  [NM][32];
  int          m_head [NM];
  int          m_tail [NM];
  int          rr_model = NM - 1;
  int          ar_lat_k = 0, r_lat_k = 0, rr_lat_k = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] slv_rdata(input logic [31:0] a);
    if (a == 32'h1000) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [1:0] slv_rresp(input logic [31:0] a);
    if (a == 32'h1000) return 2'b00;
    return a[3:2];
  endfunction

  function automatic int pick(input int k);
    return (k < 0) ? int'($urandom_range(0, 3)) : k;
  endfunction

  task automatic add_req(input int m, input logic [31:0] a, input logic [3:0] q);
    m_addr[m][m_tail[m]] = a;
    m_qos[m][m_tail[m]]  = q;
    m_tail[m]++;
  endtask

  // Reference order: each master presents its queue head; repeatedly serve the
  // highest QoS, ties going to the first master after the last one served.
  task automatic launch();
    int   h [NM];
    int   rr, best, bq, idx;
    exp_t e;
    rr = rr_model;
    for (int i = 0; i < NM; i++) h[i] = m_head[i];
    while (1) begin
      best = -1;
      bq   = -1;
      for (int off = 1; off <= NM; off++) begin
        idx = (rr + off) % NM;
        if (h[idx] < m_tail[idx] && int'(m_qos[idx][h[idx]]) > bq) begin
          best = idx;
          bq   = int'(m_qos[idx][h[idx]]);
        end
      end
      if (best < 0) break;
      e.mst  = best;
      e.addr = m_addr[best][h[best]];
      e.qos  = m_qos[best][h[best]];
      sb.push_back(e);
      h[best]++;
      rr = best;
    end
    rr_model = rr;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !in_flight;
      for (int i = 0; i < NM; i++) if (m_head[i] != m_tail[i]) done = 1'b0;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
      in_flight = 1'b0;
    end
    for (int i = 0; i < NM; i++) begin
      m_head[i] = 0;
      m_tail[i] = 0;
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- master request drivers ----------------
  initial begin
    logic [3:0] hs;
    req_val = '0;
    for (int i = 0; i < NM; i++) begin
      req_addr[i] = '0;
      req_qos[i]  = '0;
      m_head[i]   = 0;
      m_tail[i]   = 0;
    end
    forever begin
      @(negedge clk);
      hs = req_val & reqst_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < NM; i++) begin
        if (hs[i]) m_head[i]++;
        if (m_head[i] < m_tail[i]) begin
          req_val[i]  = 1'b1;
          req_addr[i] = m_addr[i][m_head[i]];
          req_qos[i]  = m_qos[i][m_head[i]];
        end else begin
          req_val[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- master R-ready drivers ----------------
  initial begin
    int rw [NM];
    int rl [NM];
    resp_rdy = '0;
    for (int i = 0; i < NM; i++) begin
      rw[i] = 0;
      rl[i] = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NM; i++) begin
        if (resp_val[i]) begin
          if (rw[i] == 0) rl[i] = pick(rr_lat_k);
          resp_rdy[i] = (rw[i] >= rl[i]);
          rw[i]++;
        end else begin
          resp_rdy[i] = 1'($urandom_range(0, 1));
          rw[i] = 0;
        end
      end
    end
  end

  // ---------------- behavioural AXI-Lite slaves ----------------
  initial begin
    bit          arhs, rhs, pend;
    int          ar_w, ar_lat_c, r_cnt;
    logic [31:0] s_addr;
    pend = 1'b0; ar_w = 0; ar_lat_c = 0; r_cnt = 0; s_addr = '0;
    axs.ar_ready = 1'b0; axs.r_valid = 1'b0; axs.r_data = '0; axs.r_resp = '0;
    axs.aw_ready = 1'b0; axs.w_ready = 1'b0; axs.b_valid = 1'b0; axs.b_resp = '0;
    axm.ar_ready = 1'b1; axm.r_valid = 1'b0; axm.r_data = '0; axm.r_resp = '0;
    axm.aw_ready = 1'b0; axm.w_ready = 1'b0; axm.b_valid = 1'b0; axm.b_resp = '0;
    forever begin
      @(negedge clk);
      arhs = axs.ar_valid && axs.ar_ready;
      rhs  = axs.r_valid && axs.r_ready;
      if (arhs) s_addr = axs.ar_addr;
      @(posedge clk);
      #1;
      if (!rstn) begin
        axs.ar_ready = 1'b0;
        axs.r_valid  = 1'b0;
        pend = 1'b0;
        ar_w = 0;
      end else begin
        if (rhs) begin
          axs.r_valid = 1'b0;
          pend = 1'b0;
        end
        if (arhs) begin
          pend  = 1'b1;
          r_cnt = pick(r_lat_k);
        end
        if (pend && !axs.r_valid) begin
          if (r_cnt == 0) begin
            axs.r_valid = 1'b1;
            axs.r_data  = slv_rdata(s_addr);
            axs.r_resp  = slv_rresp(s_addr);
          end else begin
            r_cnt--;
          end
        end
        if (axs.ar_valid) begin
          if (ar_w == 0) ar_lat_c = pick(ar_lat_k);
          axs.ar_ready = (ar_w >= ar_lat_c);
          ar_w++;
        end else begin
          axs.ar_ready = 1'b0;
          ar_w = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit   busy;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        busy = in_flight;
        if (in_flight) begin
          chk("resp_val", resp_val, axs.r_valid ? (4'b0001 << cur.mst) : 4'b0000);
          chk("r_ready", axs.r_ready, resp_rdy[cur.mst]);
          if (axs.r_valid) begin
            rv_run++;
            chk("resp_data", resp_data, {slv_rdata(cur.addr), slv_rresp(cur.addr)});
            if (axs.r_ready) begin
              in_flight = 1'b0;
              last_rv   = rv_run;
              rv_run    = 0;
            end
          end
        end else begin
          chk("resp_val_idle", resp_val, 4'b0000);
          chk("r_ready_idle", axs.r_ready, 1'b0);
        end
        if (axs.ar_valid) begin
          arv_run++;
          if (busy) begin
            n_cmp++; n_bad++;
            $display("FAIL ar_overlap: got ar_valid=1 expected 0 while read outstanding");
          end else if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_ar: got ar_addr %0h expected no request", axs.ar_addr);
          end else begin
            e = sb[0];
            chk("ar_addr", axs.ar_addr, e.addr);
            chk("ar_qos", axs.ar_qos, e.qos);
            chk("req_hold", req_val[e.mst], 1'b1);
            chk("reqst_rdy", reqst_rdy, axs.ar_ready ? (4'b0001 << e.mst) : 4'b0000);
            if (axs.ar_ready) begin
              void'(sb.pop_front());
              cur       = e;
              in_flight = 1'b1;
              hs_cyc.push_back(cyc);
              last_arv  = arv_run;
              arv_run   = 0;
            end
          end
        end else begin
          chk("reqst_rdy_idle", reqst_rdy, 4'b0000);
        end
        if (mask_phase) begin
          chk("mask_ar_valid", axm.ar_valid, 1'b0);
          chk("mask_rdy1", reqst_rdy_m[1], 1'b0);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int c0, c1, t0, nreq, lim;
    rstn   = 1'b0;
    rstn_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_valid", axs.ar_valid, 1'b0);
    chk("rst_reqst_rdy", reqst_rdy, 4'b0000);
    chk("rst_resp_val", resp_val, 4'b0000);
    chk("rst_resp_data", resp_data, 34'd0);
    chk("rst_r_ready", axs.r_ready, 1'b0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single request, latency from request to ar_valid.
    add_req(1, 32'h1000, 4'd0);
    launch();
    c0 = -1; c1 = -1;
    for (int k = 0; k < 10 && c0 < 0; k++) begin
      @(negedge clk);
      if (req_val != 4'b0000) c0 = cyc;
    end
    for (int k = 0; k < 10 && c1 < 0; k++) begin
      if (axs.ar_valid) c1 = cyc;
      else @(negedge clk);
    end
    chk("ar_latency", c1 - c0, 1);
    drain();

    // QoS priority, then park the pointer on master 3.
    add_req(0, 32'h2000, 4'd2);
    add_req(2, 32'h3000, 4'd9);
    launch();
    drain();
    add_req(3, 32'h3300, 4'd4);
    launch();
    drain();

    // Equal QoS, continuous requests: rotation and 3-cycle throughput.
    hs_cyc.delete();
    for (int r = 0; r < 2; r++) begin
      for (int m = 0; m < 3; m++) add_req(m, 32'h4000 + 32'(16 * (3 * r + m)), 4'd5);
    end
    launch();
    drain();
    for (int k = 1; k < hs_cyc.size(); k++) chk("xact_cycles", hs_cyc[k] - hs_cyc[k-1], 3);
    chk("xact_count", hs_cyc.size(), 6);

    // Slave address stall then master response stall.
    ar_lat_k = 5; r_lat_k = 0; rr_lat_k = 3;
    add_req(1, 32'h4444, 4'd7);
    launch();
    drain();
    chk("ar_stall_cycles", last_arv, 6);
    chk("r_stall_cycles", last_rv, 4);

    // Reset while a response is waiting.
    ar_lat_k = 0; r_lat_k = 0; rr_lat_k = 20;
    add_req(2, 32'h5000, 4'd1);
    launch();
    c0 = 0;
    for (int k = 0; k < 20 && c0 == 0; k++) begin
      @(negedge clk);
      if (resp_val != 4'b0000) c0 = 1;
    end
    chk("reach_r_state", c0, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_ar_valid", axs.ar_valid, 1'b0);
    chk("midrst_reqst_rdy", reqst_rdy, 4'b0000);
    chk("midrst_resp_val", resp_val, 4'b0000);
    chk("midrst_resp_data", resp_data, 34'd0);
    chk("midrst_r_ready", axs.r_ready, 1'b0);
    sb.delete();
    in_flight = 1'b0;
    for (int i = 0; i < NM; i++) begin
      m_head[i] = 0;
      m_tail[i] = 0;
    end
    rr_model = NM - 1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rr_lat_k = 0;
    @(negedge clk);
    add_req(0, 32'h6000, 4'd5);
    add_req(3, 32'h7000, 4'd5);
    launch();
    drain();

    // Masked master never reaches the masked node's slave.
    rstn_m = 1'b1;
    mask_phase = 1'b1;
    for (int r = 0; r < 8; r++) add_req(1, 32'h8000 + 32'(16 * r), 4'd3);
    launch();
    t0 = cyc;
    drain();
    mask_phase = 1'b0;
    chk("mask_window", (cyc - t0) >= 20, 1'b1);
    rstn_m = 1'b0;

    // Randomized batches.
    for (int b = 0; b < 40; b++) begin
      ar_lat_k = ($urandom_range(0, 1) == 0) ? 0 : -1;
      r_lat_k  = ($urandom_range(0, 1) == 0) ? 0 : -1;
      rr_lat_k = ($urandom_range(0, 1) == 0) ? 0 : -1;
      lim = (b % 2 == 0) ? 15 : 1;
      for (int m = 0; m < NM; m++) begin
        nreq = int'($urandom_range(0, 4));
        for (int r = 0; r < nreq; r++) add_req(m, $urandom, 4'($urandom_range(0, lim)));
      end
      launch();
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/liteic_slave_node_read.md
Name: liteic_slave_node_read

Overview:
- Slave-side read node of the liteic crossbar. One instance per slave slot.
- Takes AR requests from every master read node through the crossbar matrix and arbitrates among them by QoS, with round-robin between equal QoS.
- Forwards the granted request to one AXI-Lite slave and routes the R response back to the granting master only.
- Strictly one outstanding read per slave.

Parameters:
- NUM_MST, default IC_NUM_MASTER_SLOTS (pkg): number of master slots on the crossbar.
- MST_MASK, default '1: per-master connectivity. Requests from masters with a 0 bit are ignored and never acknowledged.
- ADDR_W, default IC_ARADDR_WIDTH (pkg): AR address width.
- RDATA_W, default IC_RDATA_WIDTH (pkg): response width, equal to rdata width + 2 (rresp in the low bits).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, active-low, asynchronous.
- cbar_reqst_val_i  in  NUM_MST  per-master AR valid.
- cbar_reqst_data_i  in  ADDR_W x NUM_MST (unpacked)  per-master AR address.
- cbar_reqst_arqos_i  in  4 x NUM_MST (unpacked)  per-master AR QoS.
- cbar_reqst_rdy_o  out  NUM_MST  per-master AR ready.
- cbar_resp_data_o  out  RDATA_W  {r_data, r_resp}, shared by all masters.
- cbar_resp_val_o  out  NUM_MST  per-master R valid.
- cbar_resp_rdy_i  in  NUM_MST  per-master R ready.
- slv_axil  interface  -  axi_lite_if towards the slave. Uses ar_valid/ar_ready/ar_addr/ar_qos and r_valid/r_ready/r_data/r_resp.

Behaviour:
- Reset, asynchronous active-low, effective at any time including mid-transaction:
  - state = IDLE, grant_r = 0, addr_r = 0, qos_r = 0.
  - rr_last_r = NUM_MST-1, so master 0 is favoured first after reset.
  - All outputs 0: ar_valid, r_ready, cbar_reqst_rdy_o, cbar_resp_val_o, cbar_resp_data_o.
- FSM states: IDLE, AR, R.
- IDLE:
  - req = cbar_reqst_val_i & MST_MASK.
  - If req != 0: pick the highest arqos (15 beats 0). Ties go to the first requester after rr_last_r, in ascending index order with wrap-around.
  - Register grant_r (one-hot), addr_r and qos_r from the winner, then go to AR.
  - No request: stay in IDLE, all outputs 0.
- AR:
  - ar_valid = 1; ar_addr = addr_r; ar_qos = qos_r.
  - cbar_reqst_rdy_o = grant_r & {NUM_MST{ar_ready}}. This is combinational, in the same cycle as the slave handshake.
  - On ar_valid & ar_ready, go to R.
  - ar_addr and ar_qos are stable while ar_valid is high. No other master is acked.
- R:
  - cbar_resp_val_o = grant_r & {NUM_MST{r_valid}}.
  - cbar_resp_data_o = {r_data, r_resp}, valid while r_valid.
  - r_ready = |(cbar_resp_rdy_i & grant_r).
  - On r_valid & r_ready: rr_last_r = grant_r, go to IDLE.
- Latency and throughput:
  - Request at cycle N in IDLE gives ar_valid at N+1.
  - Minimum 3 cycles per transaction with zero-wait slave and master: IDLE, AR, R.
- Requests arriving while in AR or R wait; they are never dropped or acked.
- If the granted master deasserts val in AR, that is a protocol violation. The bench asserts on it; the RTL still completes the registered request.
- slv_axil r_valid outside state R is ignored; the bench flags it.
- Unused write channels of slv_axil are tied to 0.

Decomposition:
- liteic_pkg:
  - IC_NUM_MASTER_SLOTS.
  - typedef enum logic [1:0] {IDLE, AR, R} liteic_slv_rd_state_t.
  - Constant IC_QOS_WIDTH = 4.
- Sub-module liteic_qos_rr_arbiter (purely combinational, reusable by the write path):
  - Inputs: req, qos array, rr_last.
  - Output: one-hot grant.
  - Selection: max-QoS mask first, then round-robin over the masked requesters.
- rr_last_r is held in the parent module.

Test Plan:
- Master 1 requests addr 0x1000, qos 0; slave ar_ready=1 -> ar_valid and ar_addr=0x1000 at cycle+1, cbar_reqst_rdy_o=0b0010 in that same cycle. Slave returns r_data=0xDEADBEEF, r_resp=0 -> cbar_resp_val_o=0b0010, cbar_resp_data_o={0xDEADBEEF,2'b00}.
- Masters 0 (qos 2) and 2 (qos 9) request simultaneously -> master 2 served first, then master 0. No overlap on ar_valid.
- Masters 0, 1, 2 at equal qos 5, held valid continuously -> grant order 0, 1, 2, 0, 1, each transaction 3 cycles with zero-wait slave.
- ar_ready low for 5 cycles, then r_ready held low by master for 3 cycles -> ar_addr/ar_qos and cbar_resp_data_o stable throughout, cbar_reqst_rdy_o stays 0 until handshake, no new grant issued.
- Assert rstn_i low while in R with r_valid=1 -> all outputs 0 immediately. After release, with masters 0 and 3 requesting at equal qos, master 0 is granted first.
- MST_MASK=0b1101 and master 1 requests alone -> ar_valid never asserts and cbar_reqst_rdy_o[1] stays 0 for 20 cycles.
